// File: rtl/ramfifo_rr_drain.sv
// ramfifo_rr_drain
//
// Round-robin drain stage for the multi-context RAM FIFO. Each cycle it picks at
// most one non-empty context, pops it, and captures that context's show-ahead head
// word. The result is one tagged stream through a 2-entry output buffer with a
// valid/ready handshake.
//
// Optional feature macro: RAMFIFO_DRAIN_BURST_EN
//   defined   -> the arbiter may stay on the last context for up to BURST_LEN
//                consecutive grants.
//   undefined -> strict round-robin; BURST_LEN is ignored.
//
// Ports
//   clock      : single clock for the whole block
//   reset      : asynchronous, active-low reset
//   has_data   : per-context non-empty flags from the FIFO
//   fifo_dout  : per-context show-ahead heads, context c at [c*WIDTH +: WIDTH]
//   read       : pop strobe to the FIFO
//   rcc_id     : context popped when read=1 (holds the last grant otherwise)
//   out_data   : head word of the output buffer
//   out_ctx    : context tag of out_data
//   out_valid  : output buffer non-empty
//   out_ready  : consumer accept
//   error      : sticky protocol-error flag
module ramfifo_rr_drain #(
   parameter int WIDTH     = 16,
   parameter int LOG_CTX   = 3,
   parameter int BURST_LEN = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [(1<<LOG_CTX)-1:0]        has_data,
   input  logic [(1<<LOG_CTX)*WIDTH-1:0]  fifo_dout,
   output logic                           read,
   output logic [LOG_CTX-1:0]             rcc_id,
   output logic [WIDTH-1:0]               out_data,
   output logic [LOG_CTX-1:0]             out_ctx,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           error
);

   localparam int NUM_CTX = 1 << LOG_CTX;
   localparam logic [LOG_CTX-1:0] LAST_RST = LOG_CTX'(NUM_CTX - 1);

   logic [LOG_CTX-1:0] last_q;
   logic [LOG_CTX-1:0] rcc_q;
   logic [LOG_CTX-1:0] cand;
   logic [LOG_CTX-1:0] idx;
   logic               found;
   logic               grant;
   logic               pop;
   logic [WIDTH-1:0]   cand_data;

   logic [1:0]         count_q;
   logic [WIDTH-1:0]   head_data_q;
   logic [WIDTH-1:0]   tail_data_q;
   logic [LOG_CTX-1:0] head_ctx_q;
   logic [LOG_CTX-1:0] tail_ctx_q;
   logic               error_q;

`ifdef RAMFIFO_DRAIN_BURST_EN
   localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);
   // Zero means no burst in progress, so the reset value of last_q never gets
   // preferential treatment.
   logic [7:0] burst_q;
   logic       stay;
   assign stay = has_data[last_q] && (burst_q != 8'd0) && (burst_q < BURST_MAX);
`endif

   // Candidate search: last+1 first, wrapping, with last itself checked last.
   always_comb begin
      found = 1'b0;
      cand  = last_q;
      idx   = '0;
`ifdef RAMFIFO_DRAIN_BURST_EN
      if (stay) begin
         found = 1'b1;
         cand  = last_q;
      end
`endif
      for (int k = 1; k <= NUM_CTX; k++) begin
         idx = last_q + LOG_CTX'(k);
         if (!found && has_data[idx]) begin
            found = 1'b1;
            cand  = idx;
         end
      end
   end

   // count_q is the registered occupancy, so there is no out_ready -> read path.
   // The reset term keeps the FIFO from being popped while reset is asserted.
   assign grant     = found && (count_q != 2'd2) && reset;
   assign out_valid = (count_q != 2'd0);
   assign pop       = out_valid && out_ready;
   assign cand_data = fifo_dout[int'(cand)*WIDTH +: WIDTH];

   assign read      = grant;
   assign rcc_id    = grant ? cand : rcc_q;
   assign out_data  = head_data_q;
   assign out_ctx   = head_ctx_q;
   assign error     = error_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_q      <= LAST_RST;
         rcc_q       <= '0;
         count_q     <= 2'd0;
         head_data_q <= '0;
         tail_data_q <= '0;
         head_ctx_q  <= '0;
         tail_ctx_q  <= '0;
         error_q     <= 1'b0;
      end else begin
         if (grant) begin
            last_q <= cand;
            rcc_q  <= cand;
         end
         // The head register keeps its value when the buffer empties, so
         // out_data/out_ctx hold the last delivered word.
         unique case (count_q)
            2'd0: begin
               if (grant) begin
                  head_data_q <= cand_data;
                  head_ctx_q  <= cand;
                  count_q     <= 2'd1;
               end
            end
            2'd1: begin
               if (grant && pop) begin
                  head_data_q <= cand_data;
                  head_ctx_q  <= cand;
               end else if (grant) begin
                  tail_data_q <= cand_data;
                  tail_ctx_q  <= cand;
                  count_q     <= 2'd2;
               end else if (pop) begin
                  count_q     <= 2'd0;
               end
            end
            2'd2: begin
               if (pop) begin
                  head_data_q <= tail_data_q;
                  head_ctx_q  <= tail_ctx_q;
                  count_q     <= 2'd1;
               end
            end
            default: count_q <= 2'd0;
         endcase
         // Guard only: grant already excludes a full buffer.
         if (grant && (count_q == 2'd2)) begin
            error_q <= 1'b1;
         end
      end
   end

`ifdef RAMFIFO_DRAIN_BURST_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         burst_q <= 8'd0;
      end else if (grant) begin
         if (cand != last_q || burst_q == 8'd0) begin
            burst_q <= 8'd1;
         end else if (burst_q != BURST_MAX) begin
            burst_q <= burst_q + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ramfifo_rr_drain.sv
module tb_ramfifo_rr_drain;

   localparam int WIDTH     = 16;
   localparam int LOG_CTX   = 3;
   localparam int BURST_LEN = 4;
   localparam int NUM       = 1 << LOG_CTX;

   logic                     clock = 1'b0;
   logic                     reset = 1'b0;
   logic [NUM-1:0]           has_data;
   logic [NUM*WIDTH-1:0]     fifo_dout;
   logic                     read;
   logic [LOG_CTX-1:0]       rcc_id;
   logic [WIDTH-1:0]         out_data;
   logic [LOG_CTX-1:0]       out_ctx;
   logic                     out_valid;
   logic                     out_ready;
   logic                     error;

   ramfifo_rr_drain #(
      .WIDTH     (WIDTH),
      .LOG_CTX   (LOG_CTX),
      .BURST_LEN (BURST_LEN)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .has_data  (has_data),
      .fifo_dout (fifo_dout),
      .read      (read),
      .rcc_id    (rcc_id),
      .out_data  (out_data),
      .out_ctx   (out_ctx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .error     (error)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [LOG_CTX-1:0] ctx;
      logic [WIDTH-1:0]   data;
   } ent_t;

   int              total = 0;
   int              bad   = 0;
   logic [WIDTH-1:0] fq [NUM][$];   // upstream FIFO contents per context
   ent_t            mbuf [$];       // expected output buffer contents
   ent_t            m_shown;
   int              m_last;
   int              m_burst;
   int              m_rcc;
   logic [WIDTH-1:0] word_seq = 16'h1001;
   logic [LOG_CTX-1:0] acc [$];    // contexts of accepted words
   int              exp_q [$];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic load(int c, int n);
      for (int i = 0; i < n; i++) begin
         fq[c].push_back(word_seq);
         word_seq = word_seq + 16'h0107;
      end
   endtask

   task automatic drive();
      for (int c = 0; c < NUM; c++) begin
         has_data[c] = (fq[c].size() != 0);
         fifo_dout[c*WIDTH +: WIDTH] = (fq[c].size() != 0) ? fq[c][0] : WIDTH'($urandom);
      end
   endtask

   function automatic bit model_idle();
      if (mbuf.size() != 0) return 1'b0;
      for (int c = 0; c < NUM; c++) if (fq[c].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Which context the arbiter should pick right now, or -1 for none.
   function automatic int pick();
`ifdef RAMFIFO_DRAIN_BURST_EN
      if (fq[m_last].size() != 0 && m_burst != 0 && m_burst < BURST_LEN) return m_last;
`endif
      for (int k = 1; k <= NUM; k++) begin
         if (fq[(m_last + k) % NUM].size() != 0) return (m_last + k) % NUM;
      end
      return -1;
   endfunction

   task automatic model_reset();
      mbuf.delete();
      for (int c = 0; c < NUM; c++) fq[c].delete();
      m_last  = NUM - 1;
      m_burst = 0;
      m_rcc   = 0;
      m_shown = '0;
   endtask

   task automatic tick();
      int   c;
      bit   g;
      ent_t e;
      drive();
      @(negedge clock);
      c = pick();
      g = (c >= 0) && (mbuf.size() < 2) && (reset == 1'b1);
      chk("read", 32'(read), 32'(g));
      chk("rcc_id", 32'(rcc_id), g ? 32'(c) : 32'(m_rcc));
      if (mbuf.size() != 0) m_shown = mbuf[0];
      chk("out_valid", 32'(out_valid), 32'(mbuf.size() != 0));
      chk("out_data", 32'(out_data), 32'(m_shown.data));
      chk("out_ctx", 32'(out_ctx), 32'(m_shown.ctx));
      chk("error", 32'(error), 32'd0);
      if (out_valid && out_ready) acc.push_back(out_ctx);
      @(posedge clock);
      if (mbuf.size() != 0 && out_ready) void'(mbuf.pop_front());
      if (g) begin
         e.ctx  = LOG_CTX'(c);
         e.data = fq[c][0];
         void'(fq[c].pop_front());
         mbuf.push_back(e);
         if (c == m_last && m_burst != 0) m_burst = (m_burst < BURST_LEN) ? m_burst + 1 : m_burst;
         else m_burst = 1;
         m_last = c;
         m_rcc  = c;
      end
      #1;
   endtask

   task automatic drain(string tag);
      out_ready = 1'b1;
      for (int i = 0; i < 200 && !model_idle(); i++) tick();
      tick();
      chk({tag, "_drained"}, 32'(out_valid), 32'd0);
   endtask

   task automatic check_seq(string tag, int expv [$]);
      chk({tag, "_len"}, 32'(acc.size()), 32'(expv.size()));
      for (int i = 0; i < expv.size() && i < acc.size(); i++) chk(tag, 32'(acc[i]), 32'(expv[i]));
      acc.delete();
   endtask

   initial begin
      out_ready = 1'b0;
      has_data  = '0;
      fifo_dout = '0;
      model_reset();

      // Reset held with traffic present: nothing may pop, outputs are zero.
      load(0, 2);
      load(7, 2);
      drive();
      repeat (2) begin
         @(negedge clock);
         chk("rst_read", 32'(read), 32'd0);
         chk("rst_rcc_id", 32'(rcc_id), 32'd0);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out_data", 32'(out_data), 32'd0);
         chk("rst_out_ctx", 32'(out_ctx), 32'd0);
         chk("rst_error", 32'(error), 32'd0);
      end
      @(posedge clock);
      #1 reset = 1'b1;

      // Wrap: last=7, only contexts 0 and 7 hold data.
      drain("wrap");
`ifdef RAMFIFO_DRAIN_BURST_EN
      exp_q = '{0, 0, 7, 7};
`else
      exp_q = '{0, 7, 0, 7};
`endif
      check_seq("wrap_seq", exp_q);

      // Round-robin over sparse contexts.
      load(1, 2);
      load(3, 2);
      load(6, 2);
      drain("rr");
`ifdef RAMFIFO_DRAIN_BURST_EN
      exp_q = '{1, 1, 3, 3, 6, 6};
`else
      exp_q = '{1, 3, 6, 1, 3, 6};
`endif
      check_seq("rr_seq", exp_q);

      // Burst pattern (strict rotation when the feature is off).
      load(1, 6);
      load(2, 2);
      drain("burst");
`ifdef RAMFIFO_DRAIN_BURST_EN
      exp_q = '{1, 1, 1, 1, 2, 2, 1, 1};
`else
      exp_q = '{1, 2, 1, 2, 1, 1, 1, 1};
`endif
      check_seq("burst_seq", exp_q);

      // Backpressure: two pops, then read stays low until the consumer returns.
      out_ready = 1'b0;
      load(2, 5);
      repeat (5) tick();
      chk("bp_full", 32'(out_valid), 32'd1);
      drain("bp");
      exp_q = '{2, 2, 2, 2, 2};
      check_seq("bp_seq", exp_q);

      // Empty race: a single word, has_data drops right after the pop.
      load(5, 1);
      drain("race");
      exp_q = '{5};
      check_seq("race_seq", exp_q);

      // Random traffic and consumer stalls.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) load($urandom_range(0, NUM - 1), $urandom_range(1, 3));
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain("rand");
      acc.delete();

      // Reset mid-operation discards buffered words.
      out_ready = 1'b0;
      load(4, 3);
      load(6, 2);
      repeat (3) tick();
      reset = 1'b0;
      #2;
      chk("midrst_read", 32'(read), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      chk("midrst_rcc_id", 32'(rcc_id), 32'd0);
      model_reset();
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
